// File: rtl/uart_pkg.sv
// uart_pkg: receiver state type, bit-timing helper and width constants
// shared by the UART receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    function automatic int clks_per_bit(input int clk, input int baud);
        return clk / baud;
    endfunction

    localparam int DefClksPerBit = clks_per_bit(12000000, 230400);
    localparam int DefBitCntW    = $clog2(DefClksPerBit);
    localparam int DefDataW      = 8;
    localparam int DefBitIdxW    = $clog2(DefDataW);

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO, power-of-2 depth.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int Depth = 16,
    parameter int Width = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       wr_en_i,
    input  logic [Width-1:0]           wr_data_i,
    output logic                       full_o,
    input  logic                       rd_en_i,
    output logic [Width-1:0]           rd_data_o,
    output logic                       rd_valid_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int PtrW   = $clog2(Depth);
    localparam int CountW = $clog2(Depth + 1);

    logic [Width-1:0]  mem_q [Depth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic              empty, full, wr_ok, rd_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CountW'(Depth));
    assign rd_ok = rd_en_i & ~empty;
    assign wr_ok = wr_en_i & (~full | rd_en_i);

    // Pointer and occupancy update; pointers wrap naturally at Depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_ok && !rd_ok) count_d = count_q + 1'b1;
        else if (!wr_ok && rd_ok) count_d = count_q - 1'b1;
    end

    // Control state; reset empties the FIFO at once.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; stale contents are masked by the empty check.
    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign full_o     = full;
    assign rd_valid_o = ~empty;
    assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: mid-bit-sampling 8N1 receiver feeding a FWFT byte FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames instead.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FPGAClkSpeed = 12000000,
    parameter int BaudRate6502 = 230400,
    parameter int FifoDepth    = 16,
    parameter int data_width   = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_ni,
    input  logic                           uart_rx_i,
    input  logic                           rd_en_i,
    output logic [data_width-1:0]          rd_data_o,
    output logic                           rd_valid_o,
    output logic [$clog2(FifoDepth+1)-1:0] count_o,
    output logic                           frame_err_o,
    output logic                           overrun_o,
    input  logic                           clr_err_i
);

    localparam int ClksPerBit = clks_per_bit(FPGAClkSpeed, BaudRate6502);
    localparam int CntW       = $clog2(ClksPerBit);
    localparam int IdxW       = (data_width > 1) ? $clog2(data_width) : 1;

    localparam logic [CntW-1:0] HalfLoad = CntW'(ClksPerBit / 2 - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(ClksPerBit - 1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(data_width - 1);

    logic [1:0]            sync_q, sync_d;
    logic                  prev_q, prev_d;
    logic                  rx_s, fall, tick;
    rx_state_t             state_q;
    logic [CntW-1:0]       timer_q;
    logic [IdxW-1:0]       bit_q;
    logic [data_width-1:0] shift_q;
    logic                  push, ferr_set, full;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic                  par_err_q;
`endif

    assign rx_s = sync_q[1];
    assign fall = prev_q & ~rx_s;
    assign tick = (timer_q == '0);

    // Two-stage synchronizer plus one delay stage for edge detection.
    always_comb begin
        sync_d = {sync_q[0], uart_rx_i};
        prev_d = sync_q[1];
    end

    // Synchronizer flops idle high so reset never looks like a start bit.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Frame receiver: half-bit delay to the start centre, then bit periods.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fall) begin
                        state_q <= START;
                        timer_q <= HalfLoad;
                    end
                end
                START: begin
                    if (!tick) begin
                        timer_q <= timer_q - 1'b1;
                    end else if (!rx_s) begin
                        state_q <= DATA;
                        timer_q <= FullLoad;
                        bit_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DATA: begin
                    if (!tick) begin
                        timer_q <= timer_q - 1'b1;
                    end else begin
                        shift_q <= {rx_s, shift_q[data_width-1:1]};
                        timer_q <= FullLoad;
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == LastIdx) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (!tick) begin
                        timer_q <= timer_q - 1'b1;
                    end else begin
                        par_err_q <= ^{shift_q, rx_s};
                        timer_q   <= FullLoad;
                        state_q   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (!tick) timer_q <= timer_q - 1'b1;
                    else state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stop-bit sample decides push versus framing error on the same edge.
`ifdef UART_RX_PARITY_EN
    assign push     = (state_q == STOP) & tick & rx_s & ~par_err_q;
    assign ferr_set = (state_q == STOP) & tick & (~rx_s | par_err_q);
`else
    assign push     = (state_q == STOP) & tick & rx_s;
    assign ferr_set = (state_q == STOP) & tick & ~rx_s;
`endif

    // Sticky error flags; clear wins over a same-cycle set.
    always_comb begin
        frame_err_d = frame_err_q | ferr_set;
        overrun_d   = overrun_q | (push & full & ~rd_en_i);
        if (clr_err_i) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    sync_fifo #(
        .Depth(FifoDepth),
        .Width(data_width)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .wr_en_i   (push),
        .wr_data_i (shift_q),
        .full_o    (full),
        .rd_en_i   (rd_en_i),
        .rd_data_o (rd_data_o),
        .rd_valid_o(rd_valid_o),
        .count_o   (count_o)
    );

    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive path for the 6502 system UART: 16x-free mid-bit-sampling 8N1 receiver followed by a first-word-fall-through byte FIFO. Sits directly between the `uart_rx_i` pad and the 6502 UART peripheral register logic, which pops bytes through a simple read strobe. Decouples serial arrival at `BaudRate6502` from CPU polling latency and reports framing and overrun errors as sticky flags.

## Interface
Parameters:
- `FPGAClkSpeed`, 12000000: clock frequency in Hz.
- `BaudRate6502`, 230400: serial bit rate.
- `FifoDepth`, 16: FIFO entries; must be a power of 2, minimum 2.
- `data_width`, 8: data bits per frame and FIFO width.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`, input, 1: system clock.
- `reset_ni`, input, 1: asynchronous active-low reset.
- `uart_rx_i`, input, 1: raw serial line, idle high, asynchronous to `clk_i`.
- `rd_en_i`, input, 1: pop strobe, one pop per cycle high.
- `rd_data_o`, output, `data_width`: FIFO head byte; 0 when empty.
- `rd_valid_o`, output, 1: FIFO not empty.
- `count_o`, output, `$clog2(FifoDepth+1)`: current occupancy.
- `frame_err_o`, output, 1: sticky flag, stop bit sampled low.
- `overrun_o`, output, 1: sticky flag, byte dropped because FIFO full.
- `clr_err_i`, input, 1: clears both sticky flags.

## Operation
- `uart_rx_i` passes through a 2-FF synchronizer (reset to 1). Falling-edge detect uses the synchronized value against its 1-cycle delay.
- `ClksPerBit` = `FPGAClkSpeed/BaudRate6502`, truncated (52 at defaults). Bit counter width is `$clog2(ClksPerBit)`.
- State machine:
  - IDLE: on falling edge, load `ClksPerBit/2 - 1` and go to START.
  - START: at timer expiry, if the line is low, go to DATA; if high, treat as a glitch and return to IDLE.
  - DATA: sample every `ClksPerBit` clocks, LSB first, into the shift register. After `data_width` bits go to PARITY if compiled in, else STOP.
  - STOP: sample once.
    - High: push the byte.
    - Low: discard the byte and set `frame_err_o`.
    - In both cases return to IDLE. IDLE requires a new falling edge, so a held-low line does not re-trigger.
- FIFO behaviour:
  - Push when full: byte dropped, `overrun_o` set, contents unchanged.
  - Push and pop in the same cycle when full: both are accepted and the count is unchanged.
  - `rd_en_i` while empty is ignored.
  - Read and write pointers wrap modulo `FifoDepth`.
- `clr_err_i` has priority over a same-cycle set.

## Timing
- Reset values: `rd_data_o` 0, `rd_valid_o` 0, `count_o` 0, `frame_err_o` 0, `overrun_o` 0, FSM in IDLE, synchronizer at 1.
- Pad-to-detect latency: 3 clocks (2 synchronizer stages plus edge register).
- Stop-bit sample edge to push: the same edge. `rd_valid_o`, `count_o` and `rd_data_o` update 1 cycle later, and the error flags update at the same time.
- Pop: `rd_data_o` shows the next entry, and `count_o` decrements, 1 cycle after the `rd_en_i` edge.
- Reset assertion mid-frame: the partial byte is lost and FIFO contents are cleared immediately (asynchronous). After deassertion the receiver waits for a fresh falling edge.

## Configuration
- `UART_RX_PARITY_EN` defined: frame is 8E1. The PARITY state samples one extra bit.
  - Even-parity mismatch discards the byte and sets `frame_err_o`.
  - STOP then follows as normal.
- `UART_RX_PARITY_EN` undefined: frame is 8N1, and the PARITY state and its logic are absent.

## Structure
- `uart_pkg` holds:
  - the `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - a `clks_per_bit(clk, baud)` function;
  - the `clog2`-derived width constants shared with the future TX block.
- One sub-module: `sync_fifo`, FWFT, parameterized by depth and width, with the same asynchronous active-low reset. It is reused later by the TX path.

## Test plan
- Defaults. Send 0xA5 at 52 clocks/bit → `rd_valid_o`=1, `rd_data_o`=0xA5, `count_o`=1. Pulse `rd_en_i` → `count_o`=0, `rd_data_o`=0.
- 10-clock low glitch on an idle line → no push, FSM back in IDLE, `count_o` stays 0.
- Frame 0x3C with stop bit forced low → `frame_err_o`=1, `count_o`=0. Pulse `clr_err_i` → flag 0. The next good 0x3C lands in the FIFO.
- 17 back-to-back bytes 0x00–0x10, no reads → `count_o`=16, `overrun_o`=1. Drain yields 0x00–0x0F in order and wraps the pointers cleanly.
- FIFO full plus push with same-cycle `rd_en_i` → `count_o` stays 16, `overrun_o` stays 0, and the new byte appears last on drain.
- Assert `reset_ni` low mid-byte with 3 bytes queued → all outputs at reset values at once. After release, 0x5A is received correctly.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 1 → accepted; with parity bit 0 → `frame_err_o`=1, no push.
